// File: rtl/minirisc_mc_sequencer.sv
// miniRISC multi-cycle control sequencer: FETCH-DECODE-EXEC-MEM-WB
// with PC ownership, memory wait/timeout, halt/fault and retire count.
module minirisc_mc_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 15,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [2:0]        instr_class,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic              ir_load,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              rf_we,
  output logic [2:0]        state,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int TW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  localparam logic [2:0] CL_LOAD   = 3'd1;
  localparam logic [2:0] CL_STORE  = 3'd2;
  localparam logic [2:0] CL_BRANCH = 3'd3;
  localparam logic [2:0] CL_CALL   = 3'd4;
  localparam logic [2:0] CL_HALT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  state_e            st_q, st_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d, pc_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [2:0]        cls_q, cls_d;
  logic              retire, to_hit, wait_inc;
  logic              imem_req_q, dmem_req_q, dmem_we_q;
  logic              rf_we_q, halted_q, fault_q;

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    cls_d    = cls_q;
    tmr_d    = tmr_q;
    retire   = 1'b0;
    wait_inc = 1'b0;
    pc_inc   = pc_q + ADDR_W'(1);
    to_hit   = TO_EN && (tmr_q == TMAX);
    unique case (st_q)
      S_IDLE: if (run) st_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready)  st_d = S_DECODE;
        else if (to_hit) st_d = S_FAULT;
        else             wait_inc = 1'b1;
      end
      S_DECODE: begin
        cls_d = instr_class;
        unique case (1'b1)
          (instr_class[2] & instr_class[1]): st_d = S_FAULT;
          (instr_class == CL_HALT):          st_d = S_HALT;
          default:                           st_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        // CALL target is only valid here; keep it for WB
        tgt_d = branch_target;
        unique case (1'b1)
          (cls_q == CL_LOAD),
          (cls_q == CL_STORE): st_d = S_MEM;
          (cls_q == CL_BRANCH): begin
            pc_d   = branch_taken ? branch_target : pc_inc;
            retire = 1'b1;
          end
          default: st_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_d   = pc_inc;
            retire = 1'b1;
          end else begin
            st_d = S_WB;
          end
        end else if (to_hit) begin
          st_d = S_FAULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        pc_d   = (cls_q == CL_CALL) ? tgt_q : pc_inc;
        retire = 1'b1;
      end
      S_HALT:  st_d = S_HALT;
      S_FAULT: st_d = S_FAULT;
    endcase
    if (retire) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      st_d  = run ? S_FETCH : S_IDLE;
    end
    if (st_d != st_q) tmr_d = '0;
    else if (wait_inc) tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= S_IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      cls_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      cls_q      <= cls_d;
      imem_req_q <= (st_d == S_FETCH);
      dmem_req_q <= (st_d == S_MEM);
      dmem_we_q  <= (st_d == S_MEM) && (cls_d == CL_STORE);
      rf_we_q    <= (st_d == S_WB);
      halted_q   <= (st_d == S_HALT);
      fault_q    <= (st_d == S_FAULT);
    end
  end

  assign pc            = pc_q;
  assign state         = st_q;
  assign retired_count = cnt_q;
  assign imem_req      = imem_req_q;
  assign ir_load       = imem_req_q & imem_ready;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign rf_we         = rf_we_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_minirisc_mc_sequencer.sv
// Self-checking bench for minirisc_mc_sequencer; retirements are
// checked against a queue of expected {pc, count} records.
module tb_minirisc_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [2:0]  instr_class;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready, dmem_ready;
  logic [31:0] pc;
  logic        imem_req, ir_load, dmem_req, dmem_we, rf_we;
  logic [2:0]  state;
  logic        halted, fault;
  logic [31:0] retired_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] prev_cnt = '0;

  minirisc_mc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .instr_class   (instr_class),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .pc            (pc),
    .imem_req      (imem_req),
    .ir_load       (ir_load),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .rf_we         (rf_we),
    .state         (state),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (retired_count > prev_cnt) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL retire_unexpected pc=%h cnt=%0d exp=none",
                 pc, retired_count);
      end else begin
        mon_e = sb.pop_front();
        if (pc !== mon_e.pc || retired_count !== mon_e.cnt) begin
          failures++;
          $display("FAIL retire pc=%h cnt=%0d exp pc=%h cnt=%0d",
                   pc, retired_count, mon_e.pc, mon_e.cnt);
        end
      end
    end
    prev_cnt = retired_count;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    instr_class = 3'd0;
    branch_taken = 1'b0;
    branch_target = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0 || pc !== 32'd0 || retired_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state st=%0d pc=%h cnt=%0d exp 0/0/0",
               state, pc, retired_count);
    end
    checks++;
    if ({imem_req, ir_load, dmem_req, dmem_we, rf_we, halted, fault}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000000",
               {imem_req, ir_load, dmem_req, dmem_we, rf_we, halted, fault});
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL idle_hold st=%0d exp=0", state);
    end
  endtask

  task automatic test_alu();
    logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd0;
    sb.push_back(exp_t'{32'd1, 32'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== seq[i]) begin
        failures++;
        $display("FAIL alu_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
      checks++;
      if (rf_we !== (seq[i] == 3'd5) || ir_load !== (seq[i] == 3'd1)) begin
        failures++;
        $display("FAIL alu_strobes[%0d] rf_we=%b ir_load=%b", i, rf_we, ir_load);
      end
    end
    checks++;
    if (pc !== 32'd1 || retired_count !== 32'd1) begin
      failures++;
      $display("FAIL alu_retire pc=%h cnt=%0d exp 1/1", pc, retired_count);
    end
  endtask

  task automatic test_load();
    logic [2:0] seq [9] =
      '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd1;
    sb.push_back(exp_t'{32'd1, 32'd1});
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (state !== seq[i]) begin
        failures++;
        $display("FAIL load_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
      checks++;
      if (dmem_req !== (seq[i] == 3'd4) || dmem_we !== 1'b0) begin
        failures++;
        $display("FAIL load_dmem[%0d] req=%b we=%b", i, dmem_req, dmem_we);
      end
      dmem_ready = (i == 6);
      if (i == 2) instr_class = 3'd7;
    end
    checks++;
    if (pc !== 32'd1) begin
      failures++;
      $display("FAIL load_pc got=%h exp=1", pc);
    end
  endtask

  task automatic test_branch();
    logic [2:0] seq [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      run = 1'b1;
      imem_ready = 1'b1;
      instr_class = 3'd3;
      branch_taken = (k == 0);
      branch_target = 32'h40;
      sb.push_back(exp_t'{(k == 0) ? 32'h40 : 32'h1, 32'd1});
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (state !== seq[i] || rf_we !== 1'b0) begin
          failures++;
          $display("FAIL br%0d_state[%0d] got=%0d rf_we=%b exp=%0d",
                   k, i, state, rf_we, seq[i]);
        end
        if (i == 2) begin
          checks++;
          if (pc !== 32'h0) begin
            failures++;
            $display("FAIL br%0d_pc_early got=%h exp=0", k, pc);
          end
        end
      end
      checks++;
      if (pc !== ((k == 0) ? 32'h40 : 32'h1)) begin
        failures++;
        $display("FAIL br%0d_pc got=%h", k, pc);
      end
    end
  endtask

  task automatic test_call();
    logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd4;
    branch_target = 32'h123;
    sb.push_back(exp_t'{32'h123, 32'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== seq[i] || rf_we !== (seq[i] == 3'd5)) begin
        failures++;
        $display("FAIL call_state[%0d] got=%0d rf_we=%b exp=%0d",
                 i, state, rf_we, seq[i]);
      end
    end
    checks++;
    if (pc !== 32'h123) begin
      failures++;
      $display("FAIL call_pc got=%h exp=123", pc);
    end
  endtask

  task automatic test_imem_timeout();
    logic [2:0] e;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      e = (i < 16) ? 3'd1 : 3'd7;
      checks++;
      if (state !== e || imem_req !== (i < 16)) begin
        failures++;
        $display("FAIL ito_state[%0d] got=%0d req=%b exp=%0d",
                 i, state, imem_req, e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      imem_ready = 1'b1;
      tick();
      checks++;
      if (state !== 3'd7 || fault !== 1'b1 || pc !== 32'd0
          || retired_count !== 32'd0) begin
        failures++;
        $display("FAIL fault_sticky[%0d] st=%0d fault=%b pc=%h", i,
                 state, fault, pc);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || pc !== 32'd0) begin
      failures++;
      $display("FAIL fault_clear st=%0d fault=%b pc=%h exp 0/0/0",
               state, fault, pc);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_ready_wins();
    logic [2:0] seq [4] = '{3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    instr_class = 3'd0;
    sb.push_back(exp_t'{32'd1, 32'd1});
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (state !== 3'd1) begin
        failures++;
        $display("FAIL rw_wait[%0d] got=%0d exp=1", i, state);
      end
      imem_ready = (i == 15);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== seq[i]) begin
        failures++;
        $display("FAIL rw_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
    end
  endtask

  task automatic test_dmem_timeout();
    logic [2:0] e;
    do_reset();
    run = 1'b1;
    instr_class = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      imem_ready = (i == 4);
    end
    tick();
    imem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL dto_exec got=%0d exp=3", state);
    end
    for (int j = 0; j < 17; j++) begin
      tick();
      e = (j < 16) ? 3'd4 : 3'd7;
      checks++;
      if (state !== e || dmem_we !== (j < 16)) begin
        failures++;
        $display("FAIL dto_state[%0d] got=%0d we=%b exp=%0d",
                 j, state, dmem_we, e);
      end
    end
    checks++;
    if (fault !== 1'b1 || pc !== 32'd0 || retired_count !== 32'd0) begin
      failures++;
      $display("FAIL dto_fault fault=%b pc=%h cnt=%0d", fault, pc,
               retired_count);
    end
  endtask

  task automatic test_run_pause();
    logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd2;
    sb.push_back(exp_t'{32'd1, 32'd1});
    for (int i = 0; i < 4; i++) tick();
    run = 1'b0;
    checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      failures++;
      $display("FAIL st_mem st=%0d req=%b we=%b exp 4/1/1", state,
               dmem_req, dmem_we);
    end
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    checks++;
    if (state !== 3'd0 || pc !== 32'd1 || retired_count !== 32'd1) begin
      failures++;
      $display("FAIL st_pause st=%0d pc=%h cnt=%0d exp 0/1/1", state,
               pc, retired_count);
    end
    tick();
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL st_idle got=%0d exp=0", state);
    end
    run = 1'b1;
    instr_class = 3'd0;
    sb.push_back(exp_t'{32'd2, 32'd2});
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== seq[i]) begin
        failures++;
        $display("FAIL resume_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
    end
    checks++;
    if (pc !== 32'd2) begin
      failures++;
      $display("FAIL resume_pc got=%h exp=2", pc);
    end
  endtask

  task automatic test_halt();
    logic [2:0] seq [3] = '{3'd1, 3'd2, 3'd6};
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== seq[i] || halted !== (seq[i] == 3'd6)) begin
        failures++;
        $display("FAIL halt_state[%0d] got=%0d halted=%b exp=%0d",
                 i, state, halted, seq[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      instr_class = 3'd0;
      tick();
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || pc !== 32'd0
          || retired_count !== 32'd0 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL halt_sticky[%0d] st=%0d pc=%h cnt=%0d", i,
                 state, pc, retired_count);
      end
    end
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    instr_class = 3'd1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmem_pre st=%0d req=%b exp 4/1", state, dmem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmem st=%0d req=%b exp 0/0", state, dmem_req);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0] seq [3] = '{3'd1, 3'd2, 3'd7};
    for (int c = 6; c < 8; c++) begin
      do_reset();
      run = 1'b1;
      imem_ready = 1'b1;
      instr_class = 3'(c);
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (state !== seq[i] || fault !== (seq[i] == 3'd7)) begin
          failures++;
          $display("FAIL ill%0d_state[%0d] got=%0d fault=%b exp=%0d",
                   c, i, state, fault, seq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  cls [8] = '{3'd0, 3'd3, 3'd2, 3'd1,
                             3'd4, 3'd3, 3'd3, 3'd0};
    logic        tk  [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tg  [8] = '{32'h0, 32'h10, 32'h0, 32'h0,
                             32'h80, 32'h99, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] exp_pc  = 32'd0;
    logic [31:0] exp_cnt = 32'd0;
    int          lat;
    do_reset();
    run = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      instr_class = cls[k];
      branch_taken = tk[k];
      branch_target = tg[k];
      lat = (cls[k] == 3'd3) ? 3 : (cls[k] == 3'd1) ? 5 : 4;
      if (cls[k] == 3'd4 || (cls[k] == 3'd3 && tk[k])) exp_pc = tg[k];
      else exp_pc = exp_pc + 32'd1;
      exp_cnt = exp_cnt + 32'd1;
      sb.push_back(exp_t'{exp_pc, exp_cnt});
      for (int t = 0; t < lat; t++) tick();
      checks++;
      if (state !== 3'd1 || pc !== exp_pc || retired_count !== exp_cnt) begin
        failures++;
        $display("FAIL b2b[%0d] st=%0d pc=%h cnt=%0d exp 1/%h/%0d",
                 k, state, pc, retired_count, exp_pc, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    instr_class = 3'd0;
    branch_taken = 1'b0;
    branch_target = '0;
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_call();
    test_imem_timeout();
    test_ready_wins();
    test_dmem_timeout();
    test_run_pause();
    test_halt();
    test_illegal();
    test_back_to_back();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
